// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run sequencer between the simulation top and the Core.
// On an accepted start it copies the program image into the Core instruction
// memory one word per cycle. It then holds the Core in reset for RESET_HOLD
// cycles, releases it, and counts RUN cycles until ebreak, abort or timeout.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   start, abort        run request / run cancel
//   num_insts, init_pc, cycle_limit   run setup, sampled on an accepted start
//   load_addr, load_data              host image read port (combinational data)
//   mem_we, mem_waddr, mem_wdata      instruction memory write port
//   core_reset, core_pc, core_ebreak  Core control / finish flag
//   busy, done, status, cycles        host status
module core_run_ctrl #(
  parameter int unsigned MAX_INSTS  = 1024,
  parameter int unsigned RESET_HOLD = 2,
  localparam int unsigned AW = (MAX_INSTS > 1) ? $clog2(MAX_INSTS) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] num_insts,
  input  logic [31:0]   init_pc,
  input  logic [31:0]   cycle_limit,
  output logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          core_reset,
  output logic [31:0]   core_pc,
  input  logic          core_ebreak,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [31:0]   cycles
);

  localparam int unsigned HW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE_EBREAK,
    S_DONE_TIMEOUT,
    S_DONE_ABORT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] n_words_q, n_words_d;
  logic [CW-1:0] w_cnt_q, w_cnt_d;
  logic [31:0]   limit_q, limit_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [AW-1:0] load_addr_d, mem_waddr_d;
  logic          mem_we_d, core_reset_d, busy_d, done_d;
  logic [31:0]   mem_wdata_d, core_pc_d, cycles_d;
  logic [1:0]    status_d;
  logic [CW-1:0] n_clamped;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    n_words_d    = n_words_q;
    w_cnt_d      = w_cnt_q;
    limit_d      = limit_q;
    hold_d       = hold_q;
    load_addr_d  = load_addr;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr;
    mem_wdata_d  = mem_wdata;
    core_pc_d    = core_pc;
    cycles_d     = cycles;
    status_d     = status;
    n_clamped    = (num_insts > CW'(MAX_INSTS)) ? CW'(MAX_INSTS) : num_insts;

    case (state_q)
      S_IDLE, S_DONE_EBREAK, S_DONE_TIMEOUT, S_DONE_ABORT: begin
        if (start) begin
          n_words_d   = n_clamped;
          w_cnt_d     = '0;
          limit_d     = cycle_limit;
          core_pc_d   = init_pc;
          cycles_d    = '0;
          status_d    = 2'd0;
          load_addr_d = '0;
          if (n_clamped == '0) begin
            state_d = S_HOLD;
            hold_d  = HW'(RESET_HOLD);
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d  = S_DONE_ABORT;
          status_d = 2'd3;
        end else if (w_cnt_q == n_words_q) begin
          // Last word already on the write port; this edge drops mem_we.
          state_d = S_HOLD;
          hold_d  = HW'(RESET_HOLD);
        end else begin
          mem_we_d    = 1'b1;
          mem_waddr_d = load_addr;
          mem_wdata_d = load_data;
          w_cnt_d     = w_cnt_q + CW'(1);
          // Stop at the top word so the read address never wraps.
          if (load_addr != AW'(MAX_INSTS - 1)) begin
            load_addr_d = load_addr + AW'(1);
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d  = S_DONE_ABORT;
          status_d = 2'd3;
        end else if (hold_q <= HW'(1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_DONE_ABORT;
          status_d = 2'd3;
        end else if (core_ebreak) begin
          state_d  = S_DONE_EBREAK;
          status_d = 2'd1;
        end else if ((limit_q != '0) && ((cycles + 32'd1) == limit_q)) begin
          state_d  = S_DONE_TIMEOUT;
          status_d = 2'd2;
          cycles_d = cycles + 32'd1;
        end else if (cycles != 32'hFFFF_FFFF) begin
          cycles_d = cycles + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE_EBREAK) || (state_d == S_DONE_TIMEOUT) ||
                   (state_d == S_DONE_ABORT);
    core_reset_d = (state_d != S_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_words_q  <= '0;
      w_cnt_q    <= '0;
      limit_q    <= '0;
      hold_q     <= '0;
      load_addr  <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      core_reset <= 1'b1;
      core_pc    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= 2'd0;
      cycles     <= '0;
    end else begin
      state_q    <= state_d;
      n_words_q  <= n_words_d;
      w_cnt_q    <= w_cnt_d;
      limit_q    <= limit_d;
      hold_q     <= hold_d;
      load_addr  <= load_addr_d;
      mem_we     <= mem_we_d;
      mem_waddr  <= mem_waddr_d;
      mem_wdata  <= mem_wdata_d;
      core_reset <= core_reset_d;
      core_pc    <= core_pc_d;
      busy       <= busy_d;
      done       <= done_d;
      status     <= status_d;
      cycles     <= cycles_d;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: load, hold, run, ebreak, timeout,
// abort, zero-length image, size clamp and asynchronous reset.
module tb_core_run_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 11;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] num_insts;
  logic [31:0]   init_pc;
  logic [31:0]   cycle_limit;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_reset;
  logic [31:0]   core_pc;
  logic          core_ebreak;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [31:0]   cycles;

  int checks;
  int errors;

  core_run_ctrl #(.MAX_INSTS(1024), .RESET_HOLD(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .num_insts   (num_insts),
    .init_pc     (init_pc),
    .cycle_limit (cycle_limit),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .core_reset  (core_reset),
    .core_pc     (core_pc),
    .core_ebreak (core_ebreak),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .cycles      (cycles)
  );

  // Host image: word i = 0x13570000 + 17*i
  assign load_data = 32'h1357_0000 + 32'(load_addr) * 32'd17;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [CW-1:0] n, input logic [31:0] pc,
                          input logic [31:0] lim);
    start       = 1'b1;
    num_insts   = n;
    init_pc     = pc;
    cycle_limit = lim;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; core_ebreak = 1'b0;
    num_insts = '0; init_pc = '0; cycle_limit = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (core_reset !== 1'b1 || mem_we !== 1'b0 || mem_waddr !== '0 ||
        mem_wdata !== '0 || load_addr !== '0 || core_pc !== '0) begin
      errors++;
      $display("FAIL reset_datapath: core_reset=%b mem_we=%b waddr=%0d wdata=%h laddr=%0d pc=%h exp 1 0 0 0 0 0",
               core_reset, mem_we, mem_waddr, mem_wdata, load_addr, core_pc);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 2'd0 || cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b status=%0d cycles=%0d exp 0 0 0 0",
               busy, done, status, cycles);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: busy=%b core_reset=%b exp 0 1", busy, core_reset);
    end
  endtask

  task automatic test_load_seq();
    do_start(CW'(4), 32'h80, 32'd0);
    checks++;
    if (busy !== 1'b1 || mem_we !== 1'b0 || core_reset !== 1'b1 || core_pc !== 32'h80) begin
      errors++;
      $display("FAIL load_accept: busy=%b mem_we=%b core_reset=%b pc=%h exp 1 0 1 80",
               busy, mem_we, core_reset, core_pc);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_waddr !== AW'(i) ||
          mem_wdata !== (32'h1357_0000 + 32'(i) * 32'd17) || core_reset !== 1'b1) begin
        errors++;
        $display("FAIL load_word%0d: we=%b waddr=%0d wdata=%h core_reset=%b exp 1 %0d %h 1",
                 i, mem_we, mem_waddr, mem_wdata, core_reset, i,
                 32'h1357_0000 + 32'(i) * 32'd17);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: we=%b core_reset=%b busy=%b exp 0 1 1",
                 i, mem_we, core_reset, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b0 || cycles !== 32'd0 || core_pc !== 32'h80) begin
      errors++;
      $display("FAIL run_entry: core_reset=%b cycles=%0d pc=%h exp 0 0 80",
               core_reset, cycles, core_pc);
    end
  endtask

  // Continues from the first RUN cycle left by test_load_seq.
  task automatic test_ebreak();
    int bad;
    bad = 0;
    repeat (9) begin
      @(negedge clk);
      if (core_reset !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || cycles !== 32'd9) begin
      errors++;
      $display("FAIL run_count: bad_cycles=%0d cycles=%0d exp 0 9", bad, cycles);
    end
    core_ebreak = 1'b1;
    @(negedge clk);
    core_ebreak = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 2'd1 || cycles !== 32'd9 ||
        core_reset !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ebreak_done: done=%b status=%0d cycles=%0d core_reset=%b busy=%b exp 1 1 9 1 0",
               done, status, cycles, core_reset, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || status !== 2'd1 || cycles !== 32'd9) begin
      errors++;
      $display("FAIL ebreak_hold: done=%b status=%0d cycles=%0d exp 1 1 9", done, status, cycles);
    end
  endtask

  task automatic test_timeout();
    int run_cnt, wr_cnt;
    bit hit;
    run_cnt = 0; wr_cnt = 0; hit = 0;
    do_start(CW'(1), 32'h40, 32'd5);
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (core_reset === 1'b0) run_cnt++;
      if (mem_we === 1'b1) wr_cnt++;
      if (done === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || run_cnt != 5 || wr_cnt != 1) begin
      errors++;
      $display("FAIL timeout_run: done_seen=%0d run_cycles=%0d writes=%0d exp 1 5 1",
               hit, run_cnt, wr_cnt);
    end
    checks++;
    if (status !== 2'd2 || cycles !== 32'd5) begin
      errors++;
      $display("FAIL timeout_status: status=%0d cycles=%0d exp 2 5", status, cycles);
    end
  endtask

  task automatic test_abort_load();
    int bad;
    bad = 0;
    do_start(CW'(8), 32'h0, 32'd0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== AW'(0)) begin
      errors++;
      $display("FAIL abort_w0: we=%b waddr=%0d exp 1 0", mem_we, mem_waddr);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== AW'(1)) begin
      errors++;
      $display("FAIL abort_w1: we=%b waddr=%0d exp 1 1", mem_we, mem_waddr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || status !== 2'd3 || done !== 1'b1 ||
        busy !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: we=%b status=%0d done=%b busy=%b core_reset=%b exp 0 3 1 0 1",
               mem_we, status, done, busy, core_reset);
    end
    repeat (4) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || core_reset !== 1'b1 || done !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_frozen: bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_zero_and_restart();
    do_start(CW'(0), 32'h100, 32'd0);
    checks++;
    if (busy !== 1'b1 || core_reset !== 1'b1 || mem_we !== 1'b0 || status !== 2'd0) begin
      errors++;
      $display("FAIL zero_hold0: busy=%b core_reset=%b we=%b status=%0d exp 1 1 0 0",
               busy, core_reset, mem_we, status);
    end
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_hold1: core_reset=%b we=%b exp 1 0", core_reset, mem_we);
    end
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b0 || cycles !== 32'd0) begin
      errors++;
      $display("FAIL zero_run: core_reset=%b cycles=%0d exp 0 0", core_reset, cycles);
    end
    do_start(CW'(3), 32'h200, 32'd0);
    checks++;
    if (core_pc !== 32'h100 || busy !== 1'b1 || core_reset !== 1'b0 ||
        mem_we !== 1'b0 || cycles !== 32'd1) begin
      errors++;
      $display("FAIL busy_start_ignored: pc=%h busy=%b core_reset=%b we=%b cycles=%0d exp 100 1 0 0 1",
               core_pc, busy, core_reset, mem_we, cycles);
    end
    core_ebreak = 1'b1;
    @(negedge clk);
    core_ebreak = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 2'd1 || cycles !== 32'd1) begin
      errors++;
      $display("FAIL zero_ebreak: done=%b status=%0d cycles=%0d exp 1 1 1", done, status, cycles);
    end
    do_start(CW'(0), 32'h300, 32'd0);
    checks++;
    if (cycles !== 32'd0 || status !== 2'd0 || done !== 1'b0 ||
        busy !== 1'b1 || core_pc !== 32'h300 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL restart: cycles=%0d status=%0d done=%b busy=%b pc=%h core_reset=%b exp 0 0 0 1 300 1",
               cycles, status, done, busy, core_pc, core_reset);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (status !== 2'd3 || done !== 1'b1 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold: status=%0d done=%b core_reset=%b exp 3 1 1", status, done, core_reset);
    end
  endtask

  task automatic test_clamp();
    int wr_cnt;
    logic [AW-1:0] last_addr;
    logic [31:0]   last_data;
    bit hit;
    wr_cnt = 0; hit = 0; last_addr = '0; last_data = '0;
    do_start(CW'(2047), 32'h0, 32'd1);
    for (int i = 0; i < 1200 && !hit; i++) begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        wr_cnt++;
        last_addr = mem_waddr;
        last_data = mem_wdata;
      end
      if (done === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || wr_cnt != 1024 || last_addr !== AW'(1023) || last_data !== 32'h1357_43EF) begin
      errors++;
      $display("FAIL clamp_load: done_seen=%0d writes=%0d last_addr=%0d last_data=%h exp 1 1024 1023 135743ef",
               hit, wr_cnt, last_addr, last_data);
    end
    checks++;
    if (status !== 2'd2 || cycles !== 32'd1) begin
      errors++;
      $display("FAIL limit_one: status=%0d cycles=%0d exp 2 1", status, cycles);
    end
  endtask

  task automatic test_async_reset();
    do_start(CW'(0), 32'h500, 32'd0);
    repeat (4) @(negedge clk);
    checks++;
    if (core_reset !== 1'b0 || cycles !== 32'd2) begin
      errors++;
      $display("FAIL pre_reset_run: core_reset=%b cycles=%0d exp 0 2", core_reset, cycles);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (core_reset !== 1'b1 || busy !== 1'b0 || cycles !== 32'd0 || status !== 2'd0 ||
        done !== 1'b0 || core_pc !== 32'd0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: core_reset=%b busy=%b cycles=%0d status=%0d done=%b pc=%h we=%b exp 1 0 0 0 0 0 0",
               core_reset, busy, cycles, status, done, core_pc, mem_we);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b core_reset=%b exp 0 0 1", busy, done, core_reset);
    end
  endtask

  task automatic test_start_abort_idle();
    abort = 1'b1;
    do_start(CW'(0), 32'h44, 32'd0);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || status !== 2'd0 || core_pc !== 32'h44) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b done=%b status=%0d pc=%h exp 1 0 0 44",
               busy, done, status, core_pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_seq();
    test_ebreak();
    test_timeout();
    test_abort_load();
    test_zero_and_restart();
    test_clamp();
    test_async_reset();
    test_start_abort_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run sequencer sitting between the simulation top and the Core.
- On a start pulse it copies the program image word-by-word into the Core instruction memory and latches the start PC.
- It then holds Core reset for a fixed number of cycles, releases it, and counts executed cycles until ebreak, abort or cycle-limit timeout.
- It reports completion status and the final cycle count to the host.

Parameters:
- MAX_INSTS, 1024, capacity of the instruction memory in 32-bit words; sets the address width AW = clog2(MAX_INSTS).
- RESET_HOLD, 2, number of cycles core_reset_ stays asserted after loading (valid range 1..15).

Ports:
- _clk  input  1  clock, rising edge.
- _reset  input  1  asynchronous, active-low reset.
- _start  input  1  single-cycle start request; ignored unless in IDLE or a DONE_* state.
- _abort  input  1  stop the run; honoured in LOAD, HOLD and RUN.
- _num_insts  input  AW+1  number of words to load (0..MAX_INSTS); sampled on an accepted _start.
- _init_pc  input  32  start PC; sampled on an accepted _start.
- _cycle_limit  input  32  RUN cycle budget, 0 = unlimited; sampled on an accepted _start.
- load_addr_  output  AW  host image read address.
- _load_data  input  32  host image word at load_addr_, combinational, same cycle.
- mem_we_  output  1  instruction memory write enable.
- mem_waddr_  output  AW  instruction memory write address.
- mem_wdata_  output  32  instruction memory write data.
- core_reset_  output  1  active-high reset to the Core.
- core_pc_  output  32  latched start PC to the Core.
- _core_ebreak  input  1  Core finished flag (ebreak).
- busy_  output  1  high in LOAD, HOLD and RUN.
- done_  output  1  high in any DONE_* state.
- status_  output  2  0 none, 1 ebreak, 2 timeout, 3 abort.
- cycles_  output  32  RUN cycles counted.

Behaviour:
- Reset (_reset=0, async): state IDLE.
  - core_reset_=1, mem_we_=0, mem_waddr_=0, mem_wdata_=0, load_addr_=0, core_pc_=0.
  - busy_=0, done_=0, status_=0, cycles_=0.
  - Reset mid-operation aborts immediately; no partial status is retained.
- States: IDLE, LOAD, HOLD, RUN, DONE_EBREAK, DONE_TIMEOUT, DONE_ABORT.
- IDLE/DONE_* + _start:
  - Latch _num_insts, _init_pc and _cycle_limit; core_pc_ takes _init_pc.
  - Clear cycles_ and status_; set load_addr_=0.
  - Next state is LOAD, or HOLD if _num_insts==0.
  - core_reset_ stays 1 throughout.
- LOAD, one word per cycle:
  - Register mem_we_=1, mem_waddr_=load_addr_, mem_wdata_=_load_data; increment load_addr_.
  - Write latency is 1 cycle after the address is presented.
  - After N words, go to HOLD. mem_we_ deasserts in the first HOLD cycle.
  - _num_insts greater than MAX_INSTS is clamped to MAX_INSTS.
  - load_addr_ never wraps.
- HOLD: core_reset_=1 for exactly RESET_HOLD cycles (down-counter), then RUN.
- RUN:
  - core_reset_=0.
  - cycles_ increments every RUN cycle, saturating at 0xFFFFFFFF.
  - If _core_ebreak=1: go to DONE_EBREAK with status_=1; cycles_ excludes the ebreak cycle.
  - Else if _cycle_limit!=0 and cycles_+1==_cycle_limit: go to DONE_TIMEOUT with status_=2.
- Priority within a cycle: _abort > ebreak > timeout.
  - _abort in LOAD, HOLD or RUN goes to DONE_ABORT with status_=3.
  - mem_we_ is dropped on the next edge.
- DONE_*:
  - core_reset_=1 (Core frozen), done_=1.
  - cycles_ and status_ are held until the next accepted _start.
- _start while busy_=1 is ignored.
- _start and _abort together in IDLE: the start is accepted; the abort is ignored.

Test Plan:
1. Reset release, then _start with N=4, pc=0x80, limit=0 -> mem_we_ high for exactly 4 cycles, waddr 0..3, wdata equal to host words. Then core_reset_ high for 2 more cycles and low in RUN. core_pc_=0x80.
2. Same run with _core_ebreak raised on the 10th RUN cycle -> done_=1, status_=1, cycles_=9, core_reset_=1 on the next cycle.
3. N=1, limit=5, no ebreak -> exactly 5 RUN cycles, then status_=2, cycles_=5.
4. _abort in the 2nd LOAD cycle of N=8 -> exactly 2 writes occur, status_=3, and the Core is never released from reset.
5. N=0 -> no mem_we_ pulse, HOLD for 2 cycles, then RUN. A second _start issued during RUN is ignored; after DONE, a new _start restarts the sequence with cycles_ cleared to 0.
6. Assert async _reset low mid-RUN, between clock edges -> outputs take reset values immediately (core_reset_=1, busy_=0, cycles_=0).
